// File: rtl/sakuya_dac_pkg.sv
// Shared definitions for the DAC path: sequencer state encoding, the
// profile segment record and the width constants the DAC interface uses.
package sakuya_dac_pkg;

  // Step-size width presented to the DAC interface.
  localparam int DAC_DWIDTH = 8;
  // Segment duration width, in DAC frames.
  localparam int SEQ_CWIDTH = 16;
  // Pass counter width.
  localparam int LOOP_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DONE
  } seq_state_e;

  typedef struct packed {
    logic [DAC_DWIDTH-1:0] step;
    logic [SEQ_CWIDTH-1:0] len;
  } seg_t;

endpackage

// File: rtl/chirp_seg_table.sv
// Profile table: NSEG entries of {step, len} in flops.
//   clk/rst_n   : clock, async active-low reset (clears every entry)
//   we/waddr    : write strobe and entry index; wstep/wlen are the data
//   raddr       : asynchronous read index; rstep/rlen are that entry
module chirp_seg_table
  import sakuya_dac_pkg::*;
#(
  parameter int DWIDTH = DAC_DWIDTH,
  parameter int NSEG   = 4,
  parameter int CWIDTH = SEQ_CWIDTH,
  localparam int AW    = $clog2(NSEG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wstep,
  input  logic [CWIDTH-1:0] wlen,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rstep,
  output logic [CWIDTH-1:0] rlen
);

  logic [NSEG-1:0][DWIDTH-1:0] step_q;
  logic [NSEG-1:0][CWIDTH-1:0] len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      len_q  <= '0;
    end else if (we) begin
      step_q[waddr] <= wstep;
      len_q[waddr]  <= wlen;
    end
  end

  assign rstep = step_q[raddr];
  assign rlen  = len_q[raddr];

endmodule

// File: rtl/chirp_seq.sv
// Chirp profile sequencer. Walks the profile table on DAC frame ticks and
// drives the DAC interface step size, giving multi-slope / multi-chirp
// sweeps without CPU involvement.
//   clk/rst_n            : clock, async active-low reset
//   tick                 : one-clk pulse per DAC frame (already synchronised)
//   cfg_we/addr/step/len : table write port, accepted only while not busy
//   cfg_nseg/cfg_loops   : last active entry / pass count (0 = forever),
//                          captured at start
//   start/stop           : begin / abort a sequence (stop wins)
//   stepsize             : step to the DAC (0 when not running)
//   seg_idx/loop_cnt     : current entry / completed passes (saturating)
//   busy/done/cfg_err    : ARM|RUN flag, completion pulse, rejected-write pulse
module chirp_seq
  import sakuya_dac_pkg::*;
#(
  parameter int DWIDTH = DAC_DWIDTH,
  parameter int NSEG   = 4,
  parameter int CWIDTH = SEQ_CWIDTH,
  localparam int AW    = $clog2(NSEG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [DWIDTH-1:0] cfg_step,
  input  logic [CWIDTH-1:0] cfg_len,
  input  logic [AW-1:0]     cfg_nseg,
  input  logic [7:0]        cfg_loops,
  input  logic              start,
  input  logic              stop,
  output logic [DWIDTH-1:0] stepsize,
  output logic [AW-1:0]     seg_idx,
  output logic [7:0]        loop_cnt,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  seq_state_e        state;
  logic [AW-1:0]     nseg_q;
  logic [7:0]        loops_q;
  logic [CWIDTH-1:0] cnt_q;

  logic              busy_st;
  logic              more_seg;
  logic [AW-1:0]     raddr;
  logic [DWIDTH-1:0] rd_step;
  logic [CWIDTH-1:0] rd_len;
  logic [CWIDTH-1:0] rd_dur;
  logic [7:0]        loop_nxt;

  assign busy_st  = (state == ST_ARM) || (state == ST_RUN);
  assign more_seg = (seg_idx < nseg_q);

  // Single read port always points at the entry that a segment expiry would
  // load next: the following entry mid-pass, entry 0 otherwise (ARM, wrap).
  assign raddr    = (state == ST_RUN && more_seg) ? seg_idx + AW'(1) : '0;
  assign rd_dur   = (rd_len == '0) ? CWIDTH'(1) : rd_len;
  assign loop_nxt = (loop_cnt == 8'hFF) ? 8'hFF : loop_cnt + 8'd1;

  chirp_seg_table #(
    .DWIDTH (DWIDTH),
    .NSEG   (NSEG),
    .CWIDTH (CWIDTH)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we && !busy_st),
    .waddr (cfg_addr),
    .wstep (cfg_step),
    .wlen  (cfg_len),
    .raddr (raddr),
    .rstep (rd_step),
    .rlen  (rd_len)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      nseg_q   <= '0;
      loops_q  <= '0;
      cnt_q    <= '0;
      stepsize <= '0;
      seg_idx  <= '0;
      loop_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= cfg_we && busy_st;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state    <= ST_ARM;
            busy     <= 1'b1;
            nseg_q   <= cfg_nseg;
            loops_q  <= cfg_loops;
            seg_idx  <= '0;
            loop_cnt <= '0;
          end
        end
        ST_ARM: begin
          if (stop) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            stepsize <= '0;
          end else if (tick) begin
            state    <= ST_RUN;
            stepsize <= rd_step;
            cnt_q    <= rd_dur;
          end
        end
        ST_RUN: begin
          // stop is checked first so it pre-empts a coincident tick.
          if (stop) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            stepsize <= '0;
          end else if (tick) begin
            if (cnt_q > CWIDTH'(1)) begin
              cnt_q <= cnt_q - CWIDTH'(1);
            end else if (more_seg) begin
              seg_idx  <= seg_idx + AW'(1);
              stepsize <= rd_step;
              cnt_q    <= rd_dur;
            end else begin
              loop_cnt <= loop_nxt;
              if (loops_q != 8'd0 && loop_nxt == loops_q) begin
                state    <= ST_DONE;
                done     <= 1'b1;
                busy     <= 1'b0;
                stepsize <= '0;
              end else begin
                seg_idx  <= '0;
                stepsize <= rd_step;
                cnt_q    <= rd_dur;
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chirp_seq.sv
module tb_chirp_seq;
  localparam int DW = 8;
  localparam int NS = 4;
  localparam int CW = 16;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_step = '0;
  logic [CW-1:0] cfg_len = '0;
  logic [AW-1:0] cfg_nseg = '0;
  logic [7:0]    cfg_loops = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [DW-1:0] stepsize;
  logic [AW-1:0] seg_idx;
  logic [7:0]    loop_cnt;
  logic          busy;
  logic          done;
  logic          cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference table contents and the expected per-frame trace.
  int m_step[NS];
  int m_len[NS];
  int exp_step[$];
  int exp_seg[$];
  int exp_loop[$];

  chirp_seq #(.DWIDTH(DW), .NSEG(NS), .CWIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_step(cfg_step), .cfg_len(cfg_len),
    .cfg_nseg(cfg_nseg), .cfg_loops(cfg_loops), .start(start), .stop(stop),
    .stepsize(stepsize), .seg_idx(seg_idx), .loop_cnt(loop_cnt),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Frame k is the interval after the k-th tick following the arming tick.
  function automatic void build(input int nseg, input int loops, input int min_frames);
    int pass;
    exp_step.delete();
    exp_seg.delete();
    exp_loop.delete();
    pass = 0;
    while ((loops != 0 && pass < loops) || (loops == 0 && exp_step.size() < min_frames)) begin
      for (int e = 0; e <= nseg; e++) begin
        int d;
        d = (m_len[e] == 0) ? 1 : m_len[e];
        for (int r = 0; r < d; r++) begin
          exp_step.push_back(m_step[e]);
          exp_seg.push_back(e);
          exp_loop.push_back(pass > 255 ? 255 : pass);
        end
      end
      pass++;
    end
  endfunction

  task automatic write_entry(input int a, input int s, input int l);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_step = DW'(s); cfg_len = CW'(l);
    @(negedge clk);
    cfg_we = 1'b0;
    m_step[a] = s;
    m_len[a]  = l;
  endtask

  task automatic pulse_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic do_start(input int nseg, input int loops);
    @(negedge clk);
    cfg_nseg = AW'(nseg); cfg_loops = 8'(loops); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full finite run against the model trace.
  task automatic run_and_check(input int nseg, input int loops, input bit gaps);
    build(nseg, loops, 0);
    do_start(nseg, loops);
    n_checks++;
    if (busy !== 1'b1 || stepsize !== '0 || seg_idx !== '0 || loop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL arm: busy=%b step=%0d seg=%0d loop=%0d, want 1/0/0/0", busy, stepsize, seg_idx, loop_cnt);
    end
    pulse_tick();
    for (int k = 0; k < exp_step.size(); k++) begin
      n_checks++;
      if (stepsize !== DW'(exp_step[k]) || seg_idx !== AW'(exp_seg[k]) ||
          loop_cnt !== 8'(exp_loop[k]) || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL frame %0d: step=%0d want %0d seg=%0d want %0d loop=%0d want %0d busy=%b done=%b",
                 k, stepsize, exp_step[k], seg_idx, exp_seg[k], loop_cnt, exp_loop[k], busy, done);
      end
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      pulse_tick();
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || stepsize !== '0 || loop_cnt !== 8'(loops)) begin
      n_fail++;
      $display("FAIL finish: done=%b busy=%b step=%0d loop=%0d, want 1/0/0/%0d", done, busy, stepsize, loop_cnt, loops);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_width: done=%b want 0", done);
    end
  endtask

  // Infinite run for nticks frames, then stop.
  task automatic run_inf_stop(input int nseg, input int nticks);
    bit seen_done;
    build(nseg, 0, nticks + 1);
    do_start(nseg, 0);
    pulse_tick();
    seen_done = 1'b0;
    for (int k = 0; k <= nticks; k++) begin
      n_checks++;
      if (stepsize !== DW'(exp_step[k]) || seg_idx !== AW'(exp_seg[k]) || loop_cnt !== 8'(exp_loop[k])) begin
        n_fail++;
        $display("FAIL inf frame %0d: step=%0d want %0d seg=%0d want %0d loop=%0d want %0d",
                 k, stepsize, exp_step[k], seg_idx, exp_seg[k], loop_cnt, exp_loop[k]);
      end
      if (done) seen_done = 1'b1;
      if (k < nticks) pulse_tick();
    end
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    n_checks++;
    if (stepsize !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop: step=%0d busy=%b, want 0/0", stepsize, busy);
    end
    repeat (4) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL inf_done: done seen=%b want 0", seen_done);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NS; i++) begin m_step[i] = 0; m_len[i] = 0; end
    repeat (3) @(negedge clk);
    n_checks++;
    if (stepsize !== '0 || seg_idx !== '0 || loop_cnt !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: step=%0d seg=%0d loop=%0d busy=%b done=%b err=%b, want all 0",
               stepsize, seg_idx, loop_cnt, busy, done, cfg_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_two_seg();
    write_entry(0, 4, 3);
    write_entry(1, 8, 2);
    run_and_check(1, 2, 1'b0);
  endtask

  task automatic test_zero_len();
    write_entry(0, 5, 0);
    run_and_check(0, 3, 1'b1);
  endtask

  task automatic test_infinite();
    write_entry(0, 4, 3);
    run_inf_stop(1, 7);
    write_entry(0, 3, 1);
    run_inf_stop(0, 300);
  endtask

  task automatic test_cfg_err();
    write_entry(0, 4, 3);
    write_entry(1, 8, 2);
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_write_err: cfg_err=%b want 0", cfg_err);
    end
    do_start(1, 0);
    pulse_tick();
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = '0; cfg_step = 8'd99; cfg_len = 16'd9;
    @(negedge clk);
    cfg_we = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b1 || stepsize !== 8'd4) begin
      n_fail++;
      $display("FAIL busy_write: cfg_err=%b step=%0d, want 1/4", cfg_err, stepsize);
    end
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_width: cfg_err=%b want 0", cfg_err);
    end
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    run_and_check(1, 1, 1'b0);
  endtask

  task automatic test_start_stop();
    @(negedge clk); start = 1'b1; stop = 1'b1; cfg_nseg = '0; cfg_loops = 8'd1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || stepsize !== '0) begin
      n_fail++;
      $display("FAIL start_stop: busy=%b step=%0d, want 0/0", busy, stepsize);
    end
    write_entry(0, 6, 2);
    write_entry(1, 7, 1);
    do_start(1, 0);
    pulse_tick();
    pulse_tick();
    n_checks++;
    if (stepsize !== 8'd6 || seg_idx !== '0) begin
      n_fail++;
      $display("FAIL pre_stop: step=%0d seg=%0d, want 6/0", stepsize, seg_idx);
    end
    @(negedge clk); tick = 1'b1; stop = 1'b1;
    @(negedge clk); tick = 1'b0; stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || stepsize !== '0 || seg_idx !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_tick: busy=%b step=%0d seg=%0d done=%b, want 0/0/0/0", busy, stepsize, seg_idx, done);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int e = 0; e < NS; e++) write_entry(e, $urandom_range(1, 255), $urandom_range(0, 3));
      run_and_check($urandom_range(0, NS - 1), $urandom_range(1, 3), 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    for (int e = 0; e < NS; e++) write_entry(e, $urandom_range(1, 255), $urandom_range(2, 4));
    do_start(NS - 1, 0);
    pulse_tick();
    pulse_tick();
    pulse_tick();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (stepsize !== '0 || seg_idx !== '0 || loop_cnt !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: step=%0d seg=%0d loop=%0d busy=%b done=%b err=%b, want all 0",
               stepsize, seg_idx, loop_cnt, busy, done, cfg_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NS; i++) begin m_step[i] = 0; m_len[i] = 0; end
    run_and_check(0, 2, 1'b0);
    run_and_check(NS - 1, 1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_two_seg();
    test_zero_len();
    test_infinite();
    test_cfg_err();
    test_start_stop();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chirp_seq.md
# chirp_seq

Chirp profile sequencer sitting directly upstream of the DAC interface. It holds a small programmable table of sweep segments (step size, duration), walks through them on DAC frame ticks, and drives the DAC interface's `stepsize` input. The result is multi-slope and multi-chirp sweeps without CPU intervention.

## Interface
- `DWIDTH`, 8: step size width; matches the DAC interface data width.
- `NSEG`, 4: number of profile table entries; power of two, ≥2.
- `CWIDTH`, 16: segment duration width, counted in DAC frames.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tick` in 1: one-`clk` pulse per DAC frame, already synchronised to `clk`.
- `cfg_we` in 1: profile table write strobe.
- `cfg_addr` in log2(NSEG): table entry index.
- `cfg_step` in DWIDTH: step size for the entry.
- `cfg_len` in CWIDTH: entry duration in ticks.
- `cfg_nseg` in log2(NSEG): index of the last active entry. Sampled at `start`.
- `cfg_loops` in 8: number of passes through the table. 0 means infinite. Sampled at `start`.
- `start` in 1: one-`clk` pulse that begins a sequence.
- `stop` in 1: one-`clk` pulse that aborts a sequence.
- `stepsize` out DWIDTH: step size driven to the DAC interface. 0 when idle.
- `seg_idx` out log2(NSEG): current table entry.
- `loop_cnt` out 8: number of passes completed in the current run.
- `busy` out 1: high in ARM and RUN.
- `done` out 1: one-`clk` pulse on normal completion.
- `cfg_err` out 1: one-`clk` pulse when a write is attempted while busy.

## Operation
- The table has NSEG entries of {step, len}, held in registers. Reset value of every entry is 0.
- A write is accepted only in IDLE. When `busy` is high, `cfg_we` is dropped and `cfg_err` pulses.
- States:
  - IDLE: `stepsize` = 0, `busy` = 0.
  - ARM: wait for the first `tick`, so the sweep is frame-aligned.
  - RUN: the normal sweeping state.
  - DONE: lasts one `clk`; `done` = 1; then goes to IDLE.
- IDLE→ARM: on `start` with no `stop` in the same cycle. At this transition `cfg_nseg` and `cfg_loops` are latched, `seg_idx` = 0, and `loop_cnt` = 0.
- ARM→RUN: on `tick`. At this transition `stepsize` = table[0].step and the duration counter is loaded with max(table[0].len, 1). A len of 0 is treated as 1.
- RUN, on each `tick`:
  - If counter > 1: decrement the counter.
  - Else, if `seg_idx` < latched `nseg`: advance to the next entry, load its step and duration.
  - Else (end of a pass): `loop_cnt`++. If the latched loops ≠ 0 and the new `loop_cnt` = loops, go to DONE. Otherwise `seg_idx` = 0 and reload entry 0.
- `loop_cnt` saturates at 255 in infinite mode. The sequence keeps running after saturation.
- `stop` in ARM or RUN goes to IDLE on the same `clk` edge. `stepsize` becomes 0 and `done` does not pulse. `stop` in IDLE has no effect.
- If `start` and `stop` arrive in the same cycle, `stop` wins.
- `start` while `busy` is ignored.
- A `stop` arriving on a `tick` cycle takes priority over that tick's segment advance.
- Reset mid-operation: all outputs return to their reset values immediately. The table contents are cleared.

## Timing
- All outputs are registered.
- Reset values: `stepsize` = 0, `seg_idx` = 0, `loop_cnt` = 0, `busy` = 0, `done` = 0, `cfg_err` = 0.
- `start` → `busy` high: 1 `clk`.
- `tick` in ARM → `stepsize` valid: 1 `clk`.
- Segment change: `stepsize` and `seg_idx` update 1 `clk` after the `tick` that expires the segment. The DAC therefore sees the new step from the following frame onward.
- Each segment lasts exactly len ticks (minimum 1).
- Total run length = loops × Σ len, in ticks.
- `done` pulses 1 `clk` after the final `tick`. `busy` falls in the same cycle that `done` pulses.
- A table write takes effect on the next `clk`.

## Structure
- Shared package `sakuya_dac_pkg`:
  - state enum: IDLE/ARM/RUN/DONE;
  - segment record typedef {step, len};
  - width constants shared with the DAC interface (DWIDTH).
- Sub-module `chirp_seg_table`: the NSEG-entry register file with a write port and an asynchronous read port. This module stays in the top-level sequencer.

## Test plan
- Write entries {step, len} = {4,3} and {8,2}; `cfg_nseg` = 1, `cfg_loops` = 2; `start`; 10 ticks → `stepsize` sequence 4,4,4,8,8,4,4,4,8,8. `done` pulses once, 1 `clk` after tick 10; `loop_cnt` = 2.
- `cfg_len` = 0 on entry 0 (step 5), `cfg_nseg` = 0, `cfg_loops` = 3 → exactly 3 ticks of step 5, then `done`.
- `cfg_loops` = 0, then `stop` after 7 ticks → `stepsize` = 0 and `busy` = 0 on the next `clk`; `done` never pulses.
- `cfg_we` while RUN → `cfg_err` pulses; reading back the table via a later run shows the entry unchanged.
- `start` and `stop` in the same cycle in IDLE → stays IDLE. `stop` coincident with a segment-ending `tick` → IDLE, with no `seg_idx` advance visible.
- Assert `rst_n` low mid-RUN → all outputs 0 asynchronously. After release, a new `start` runs from entry 0, which now has step 0.
